stdp_window_sel: RTL and testbench

Parametrised pair-based STDP update unit for a bank of `N_CH` synapses that share one postsynaptic neuron. It replaces single-cycle pre/post coincidence selection with per-synapse timing windows implemented as trace counters, and keeps a saturating weight register per synapse. It sits between the spike sources and the synapse weight consumers. It emits per-channel increment, decrement and coincidence pulses together with the updated weights.

---
 rtl/stdp_window_sel.sv | 92 +++++++++
 tb/tb_stdp_window_sel.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_window_sel.sv
// Pair-based STDP unit: per-channel pre traces and a shared post trace set the pairing
// window. Each channel keeps a saturating weight and emits registered LTP/LTD/coincidence pulses.
module stdp_window_sel #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned WIN    = 8,
  parameter int unsigned W_W    = 4,
  parameter int unsigned STEP   = 1,
  parameter int unsigned W_INIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  learn_en,
  input  logic [N_CH-1:0]       pre_spike,
  input  logic                  post_spike,
  output logic [N_CH-1:0]       incr,
  output logic [N_CH-1:0]       decr,
  output logic [N_CH-1:0]       sim,
  output logic                  any_update,
  output logic [N_CH*W_W-1:0]   weight
);

  localparam int unsigned    TR_W   = $clog2(WIN + 1);
  localparam logic [TR_W-1:0] WIN_LD = TR_W'(WIN);
  localparam logic [W_W:0]   W_MAX  = {1'b0, {W_W{1'b1}}};
  localparam logic [W_W:0]   STEP_X = (W_W + 1)'(STEP);
  localparam logic [W_W-1:0] W_RST  = W_W'(W_INIT);

  logic [TR_W-1:0]     pre_tr [N_CH];
  logic [TR_W-1:0]     post_tr;
  logic [N_CH-1:0]     ltp, ltd, co;
  logic [N_CH*W_W-1:0] weight_nxt;

  // A spike reloads the full window; otherwise the trace counts down to zero and rests.
  function automatic logic [TR_W-1:0] tr_next(input logic spike, input logic [TR_W-1:0] tr);
    if (spike)           return WIN_LD;
    else if (tr != '0)   return tr - TR_W'(1);
    else                 return '0;
  endfunction

  // Arithmetic is widened by one bit so the carry/borrow drives the clamp.
  function automatic logic [W_W-1:0] sat_add(input logic [W_W-1:0] w);
    logic [W_W:0] s;
    s = {1'b0, w} + STEP_X;
    return (s > W_MAX) ? W_MAX[W_W-1:0] : s[W_W-1:0];
  endfunction

  function automatic logic [W_W-1:0] sat_sub(input logic [W_W-1:0] w);
    logic [W_W:0] d;
    d = {1'b0, w} - STEP_X;
    return d[W_W] ? '0 : d[W_W-1:0];
  endfunction

  // Decisions use trace values from before this edge and the spikes sampled at it.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ltp        = '0;
    ltd        = '0;
    co         = '0;
    weight_nxt = weight;
    for (int i = 0; i < N_CH; i++) begin
      ltp[i] = post_spike & ~pre_spike[i] & (pre_tr[i] != '0);
      ltd[i] = pre_spike[i] & ~post_spike & (post_tr != '0);
      co[i]  = pre_spike[i] & post_spike;
      if (learn_en && ltp[i])
        weight_nxt[i*W_W +: W_W] = sat_add(weight[i*W_W +: W_W]);
      else if (learn_en && ltd[i])
        weight_nxt[i*W_W +: W_W] = sat_sub(weight[i*W_W +: W_W]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) pre_tr[i] <= '0;
      post_tr    <= '0;
      incr       <= '0;
      decr       <= '0;
      sim        <= '0;
      any_update <= 1'b0;
      weight     <= {N_CH{W_RST}};
    end else begin
      for (int i = 0; i < N_CH; i++) pre_tr[i] <= tr_next(pre_spike[i], pre_tr[i]);
      post_tr    <= tr_next(post_spike, post_tr);
      incr       <= learn_en ? ltp : '0;
      decr       <= learn_en ? ltd : '0;
      sim        <= learn_en ? co : '0;
      any_update <= learn_en & (|(ltp | ltd));
      weight     <= weight_nxt;
    end
  end

endmodule

// File: tb/tb_stdp_window_sel.sv
// Directed bench for stdp_window_sel with N_CH=4, WIN=8, W_W=4, STEP=1, W_INIT=8.
// Observations are packed as {incr, decr, sim, any_update, weight} (29 bits).
module tb_stdp_window_sel;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        learn_en = 1'b0;
  logic [3:0]  pre_spike = '0;
  logic        post_spike = 1'b0;
  logic [3:0]  incr, decr, sim;
  logic        any_update;
  logic [15:0] weight;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stdp_window_sel #(
    .N_CH(4), .WIN(8), .W_W(4), .STEP(1), .W_INIT(8)
  ) dut (
    .clk(clk), .rst(rst), .learn_en(learn_en),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .incr(incr), .decr(decr), .sim(sim),
    .any_update(any_update), .weight(weight)
  );

  function automatic logic [28:0] obs();
    return {incr, decr, sim, any_update, weight};
  endfunction

  // Apply spikes for one edge, then sample 1 time unit after it.
  task automatic step(input logic [3:0] pre, input logic post);
    pre_spike  = pre;
    post_spike = post;
    @(posedge clk);
    #1;
    pre_spike  = '0;
    post_spike = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    learn_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pre_spike  = 4'(i * 5 + 3);
      post_spike = i[0];
      @(posedge clk);
      #1;
      checks++;
      if (obs() !== {13'h0, 16'h8888}) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs(), {13'h0, 16'h8888});
      end
    end
    pre_spike  = '0;
    post_spike = 1'b0;
    rst = 1'b1;
    idle(10);
    checks++;
    if (obs() !== {13'h0, 16'h8888}) begin
      failures++;
      $display("FAIL reset_idle got=%h want=%h", obs(), {13'h0, 16'h8888});
    end
  endtask

  task automatic test_ltp();
    do_reset();
    step(4'b0001, 1'b0);
    checks++;
    if (obs() !== {13'h0, 16'h8888}) begin
      failures++;
      $display("FAIL ltp_pre_only got=%h want=%h", obs(), {13'h0, 16'h8888});
    end
    idle(2);
    step(4'b0000, 1'b1);
    checks++;
    if (obs() !== {4'b0001, 4'b0000, 4'b0000, 1'b1, 16'h8889}) begin
      failures++;
      $display("FAIL ltp_pair got=%h want=%h", obs(), {4'b0001, 4'b0000, 4'b0000, 1'b1, 16'h8889});
    end
    step(4'b0000, 1'b0);
    checks++;
    if (obs() !== {13'h0, 16'h8889}) begin
      failures++;
      $display("FAIL ltp_pulse_end got=%h want=%h", obs(), {13'h0, 16'h8889});
    end
  endtask

  task automatic test_ltd_boundary();
    do_reset();
    step(4'b0000, 1'b1);
    idle(7);
    step(4'b0100, 1'b0);
    checks++;
    if (obs() !== {4'b0000, 4'b0100, 4'b0000, 1'b1, 16'h8788}) begin
      failures++;
      $display("FAIL ltd_sep8 got=%h want=%h", obs(), {4'b0000, 4'b0100, 4'b0000, 1'b1, 16'h8788});
    end
    do_reset();
    step(4'b0000, 1'b1);
    idle(8);
    step(4'b0100, 1'b0);
    checks++;
    if (obs() !== {13'h0, 16'h8888}) begin
      failures++;
      $display("FAIL ltd_sep9 got=%h want=%h", obs(), {13'h0, 16'h8888});
    end
  endtask

  task automatic test_saturation();
    int exp_w;
    logic [15:0] exp_weight;
    do_reset();
    exp_w = 8;
    for (int k = 0; k < 10; k++) begin
      step(4'b0010, 1'b0);
      step(4'b0000, 1'b1);
      if (exp_w < 15) exp_w++;
      exp_weight = {8'h88, 4'(exp_w), 4'h8};
      checks++;
      if (incr !== 4'b0010 || decr !== 4'b0000 || any_update !== 1'b1 || weight !== exp_weight) begin
        failures++;
        $display("FAIL sat_ltp k=%0d got incr=%b decr=%b any=%b w=%h want incr=0010 decr=0000 any=1 w=%h",
                 k, incr, decr, any_update, weight, exp_weight);
      end
      idle(10);
    end
    for (int k = 0; k < 20; k++) begin
      step(4'b0000, 1'b1);
      step(4'b0010, 1'b0);
      if (exp_w > 0) exp_w--;
      exp_weight = {8'h88, 4'(exp_w), 4'h8};
      checks++;
      if (decr !== 4'b0010 || incr !== 4'b0000 || any_update !== 1'b1 || weight !== exp_weight) begin
        failures++;
        $display("FAIL sat_ltd k=%0d got incr=%b decr=%b any=%b w=%h want incr=0000 decr=0010 any=1 w=%h",
                 k, incr, decr, any_update, weight, exp_weight);
      end
      idle(10);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(4'b0001, 1'b0);
    idle(1);
    step(4'b1000, 1'b1);
    checks++;
    if (obs() !== {4'b0001, 4'b0000, 4'b1000, 1'b1, 16'h8889}) begin
      failures++;
      $display("FAIL simul got=%h want=%h", obs(), {4'b0001, 4'b0000, 4'b1000, 1'b1, 16'h8889});
    end
    step(4'b0000, 1'b0);
    checks++;
    if (obs() !== {13'h0, 16'h8889}) begin
      failures++;
      $display("FAIL simul_pulse_end got=%h want=%h", obs(), {13'h0, 16'h8889});
    end
  endtask

  task automatic test_gating_reset();
    do_reset();
    learn_en = 1'b0;
    step(4'b0001, 1'b0);
    idle(1);
    step(4'b0000, 1'b1);
    checks++;
    if (obs() !== {13'h0, 16'h8888}) begin
      failures++;
      $display("FAIL gate_off got=%h want=%h", obs(), {13'h0, 16'h8888});
    end
    do_reset();
    step(4'b0001, 1'b0);
    learn_en = 1'b1;
    idle(1);
    step(4'b0000, 1'b1);
    checks++;
    if (obs() !== {4'b0001, 4'b0000, 4'b0000, 1'b1, 16'h8889}) begin
      failures++;
      $display("FAIL gate_straddle got=%h want=%h", obs(), {4'b0001, 4'b0000, 4'b0000, 1'b1, 16'h8889});
    end
    do_reset();
    step(4'b0010, 1'b0);
    idle(1);
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== {13'h0, 16'h8888}) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", obs(), {13'h0, 16'h8888});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    step(4'b0000, 1'b1);
    checks++;
    if (obs() !== {13'h0, 16'h8888}) begin
      failures++;
      $display("FAIL reset_discard got=%h want=%h", obs(), {13'h0, 16'h8888});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ltp();
    test_ltd_boundary();
    test_saturation();
    test_simultaneous();
    test_gating_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
